// File: rtl/timer_countdown_if.sv
// Control and display bus between the keypad/entry path and the countdown engine.
// The master side issues commands and digits; the slave side is the countdown engine.
interface timer_countdown_if;
    logic       load;
    logic [3:0] ld_min_tens;
    logic [3:0] ld_min_ones;
    logic [3:0] ld_sec_tens;
    logic [3:0] ld_sec_ones;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       zero;

    modport master (
        output load, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones,
        output start, stop, clear, door_closed,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done, zero
    );

    modport slave (
        input  load, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones,
        input  start, stop, clear, door_closed,
        output min_tens, min_ones, sec_tens, sec_ones, running, done, zero
    );
endinterface

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown engine: loads a time, decrements it once per second while
// the door is shut, pauses/resumes, and pulses done when it reaches 00:00.
module timer_countdown #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRESC_W       = 7
) (
    input  logic              clk,
    input  logic              reset,
    timer_countdown_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state, state_nxt;
    bcd_time_t          digits, digits_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic               zero;
    logic               halt_req;

    // Saturate out-of-range keypad digits so the stored value is always legal BCD time.
    function automatic bcd_time_t clamp_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min_tens > 4'd9) r.min_tens = 4'd9;
        if (t.min_ones > 4'd9) r.min_ones = 4'd9;
        if (t.sec_tens > 4'd5) r.sec_tens = 4'd5;
        if (t.sec_ones > 4'd9) r.sec_ones = 4'd9;
        return r;
    endfunction

    // One-second decrement with borrow through all four digits; never applied at 00:00.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != 4'd0) begin
            r.sec_ones = t.sec_ones - 4'd1;
        end else begin
            r.sec_ones = 4'd9;
            if (t.sec_tens != 4'd0) begin
                r.sec_tens = t.sec_tens - 4'd1;
            end else begin
                r.sec_tens = 4'd5;
                if (t.min_ones != 4'd0) begin
                    r.min_ones = t.min_ones - 4'd1;
                end else begin
                    r.min_ones = 4'd9;
                    r.min_tens = t.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign zero     = (digits == '0);
    assign halt_req = bus.stop || !bus.door_closed;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        presc_nxt  = presc;

        if (bus.clear) begin
            state_nxt  = IDLE;
            digits_nxt = '0;
            presc_nxt  = '0;
        end else begin
            unique case (state)
                IDLE, PAUSE: begin
                    if (bus.start && !halt_req && !zero) begin
                        state_nxt = RUN;
                        if (state == IDLE) presc_nxt = '0;
                    end else if (bus.load) begin
                        digits_nxt = clamp_time({bus.ld_min_tens, bus.ld_min_ones,
                                                 bus.ld_sec_tens, bus.ld_sec_ones});
                        presc_nxt  = '0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_nxt = PAUSE;
                    end else if (presc == PRESC_LAST) begin
                        presc_nxt  = '0;
                        digits_nxt = dec_time(digits);
                        if (dec_time(digits) == '0) state_nxt = DONE;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            digits <= '0;
            presc  <= '0;
        end else begin
            state  <= state_nxt;
            digits <= digits_nxt;
            presc  <= presc_nxt;
        end
    end

    assign bus.min_tens = digits.min_tens;
    assign bus.min_ones = digits.min_ones;
    assign bus.sec_tens = digits.sec_tens;
    assign bus.sec_ones = digits.sec_ones;
    assign bus.running  = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.zero     = zero;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown at four ticks per second; expected values
// are hand-derived from the cycle timing of load, start, pause and clear.
module tb_timer_countdown;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    timer_countdown_if bus ();

    timer_countdown #(
        .TICKS_PER_SEC (4),
        .PRESC_W       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %04h expected %04h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] shown();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mo,
                           input logic [3:0] st, input logic [3:0] so);
        bus.ld_min_tens = mt;
        bus.ld_min_ones = mo;
        bus.ld_sec_tens = st;
        bus.ld_sec_ones = so;
        bus.load        = 1'b1;
        tick(1);
        bus.load        = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset           = 1'b1;
        bus.load        = 1'b0;
        bus.ld_min_tens = 4'd0;
        bus.ld_min_ones = 4'd0;
        bus.ld_sec_tens = 4'd0;
        bus.ld_sec_ones = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear       = 1'b0;
        bus.door_closed = 1'b1;

        tick(2);
        check("reset_digits",  shown(),            16'h0000);
        check("reset_running", {15'd0, bus.running}, 16'd0);
        check("reset_done",    {15'd0, bus.done},    16'd0);
        check("reset_zero",    {15'd0, bus.zero},    16'd1);
        reset = 1'b0;

        // Basic 00:03 countdown to done.
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        check("load_0003", shown(), 16'h0003);
        pulse_start();
        check("start_running", {15'd0, bus.running}, 16'd1);
        tick(3);
        check("s3_hold",  shown(), 16'h0003);
        tick(1);
        check("s4_0002",  shown(), 16'h0002);
        tick(4);
        check("s8_0001",  shown(), 16'h0001);
        tick(4);
        check("s12_0000", shown(), 16'h0000);
        check("s12_done", {15'd0, bus.done},    16'd1);
        check("s12_run",  {15'd0, bus.running}, 16'd0);
        check("s12_zero", {15'd0, bus.zero},    16'd1);
        tick(1);
        check("s13_done_low", {15'd0, bus.done},    16'd0);
        check("s13_idle",     {15'd0, bus.running}, 16'd0);

        // Full borrow chain 10:00 -> 09:59 and 01:00 -> 00:59.
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        pulse_start();
        tick(4);
        check("borrow_1000", shown(), 16'h0959);
        pulse_clear();
        check("clear_after_borrow", shown(), 16'h0000);
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        pulse_start();
        tick(4);
        check("borrow_0100", shown(), 16'h0059);
        pulse_clear();

        // Door opens mid-second; prescaler is retained across the pause.
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        pulse_start();
        tick(4);
        check("pause_pre_0004", shown(), 16'h0004);
        tick(2);
        bus.door_closed = 1'b0;
        tick(1);
        check("door_open_run", {15'd0, bus.running}, 16'd0);
        tick(3);
        check("paused_frozen", shown(), 16'h0004);
        bus.door_closed = 1'b1;
        pulse_start();
        check("resume_running", {15'd0, bus.running}, 16'd1);
        tick(1);
        check("resume_p1_hold", shown(), 16'h0004);
        tick(1);
        check("resume_p2_0003", shown(), 16'h0003);

        // start and stop together in RUN: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_pause", {15'd0, bus.running}, 16'd0);
        check("start_stop_hold",  shown(), 16'h0003);

        // Load in PAUSE, run, then clear mid-run: no done pulse.
        do_load(4'd0, 4'd0, 4'd0, 4'd7);
        check("pause_load_0007", shown(), 16'h0007);
        pulse_start();
        tick(2);
        pulse_clear();
        check("clear_digits",  shown(), 16'h0000);
        check("clear_running", {15'd0, bus.running}, 16'd0);
        check("clear_done",    {15'd0, bus.done},    16'd0);
        tick(1);
        check("clear_no_done", {15'd0, bus.done},    16'd0);

        // Clamp sanitisation: 12,7,8,12 -> 97:59.
        do_load(4'd12, 4'd7, 4'd8, 4'd12);
        check("clamp_9759", shown(), 16'h9759);
        pulse_clear();

        // start at 00:00 is ignored.
        pulse_start();
        check("start_zero_idle", {15'd0, bus.running}, 16'd0);
        check("start_zero_flag", {15'd0, bus.zero},    16'd1);

        // Load during RUN is ignored; reset mid-run overrides everything.
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        pulse_start();
        tick(2);
        do_load(4'd0, 4'd0, 4'd0, 4'd9);
        check("run_load_ignored", shown(), 16'h0003);
        check("run_load_running", {15'd0, bus.running}, 16'd1);
        tick(1);
        check("run_load_dec", shown(), 16'h0002);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrun_reset_digits",  shown(), 16'h0000);
        check("midrun_reset_running", {15'd0, bus.running}, 16'd0);
        check("midrun_reset_done",    {15'd0, bus.done},    16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
Countdown engine that consumes the MM:SS value produced by the timer input control path (keypad entry and digit muxing). It loads four BCD digits, decrements them once per second while the door is closed and cooking is enabled, and signals completion. It drives the magnetron-enable (running) flag and the display digit bus.

Parameters:
TICKS_PER_SEC, 100, number of clk cycles per one-second decrement (set to 4 in benches)
PRESC_W, 7, prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
load  input  1  one-cycle pulse; capture ld_* digits
ld_min_tens  input  4  BCD minutes tens
ld_min_ones  input  4  BCD minutes ones
ld_sec_tens  input  4  BCD seconds tens
ld_sec_ones  input  4  BCD seconds ones
start  input  1  one-cycle pulse; begin or resume counting
stop  input  1  one-cycle pulse; pause counting
clear  input  1  one-cycle pulse; abort and zero the timer
door_closed  input  1  level; 1 = door shut
min_tens, min_ones, sec_tens, sec_ones  output  4 each  current BCD time, registered
running  output  1  high while in RUN
done  output  1  one-cycle pulse when countdown reaches 00:00
zero  output  1  combinational: all four digits equal 0

Behaviour:
- One clock; reset is synchronous and active-high. On reset: all digits 0, prescaler 0, state IDLE, running 0, done 0.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN); done = (state==DONE).
- Per-cycle input priority: clear > (stop or !door_closed) > start > load.
- clear, in any state: next state IDLE, digits 0, prescaler 0.
- load is accepted only in IDLE or PAUSE and is ignored in RUN and DONE.
  - On load, capture digits on the next edge.
  - Clamp sanitisation: any ones digit or min_tens > 9 becomes 9; sec_tens > 5 becomes 5.
  - Load in PAUSE keeps state PAUSE and zeroes the prescaler.
- start from IDLE or PAUSE goes to RUN only if door_closed=1 and zero=0. Otherwise it is ignored.
  - From IDLE, start zeroes the prescaler.
  - From PAUSE, the prescaler value is retained.
- RUN:
  - Each cycle the prescaler increments.
  - At TICKS_PER_SEC-1 it wraps to 0 and the digits decrement by one second on that same edge.
  - First decrement occurs TICKS_PER_SEC cycles after the start edge.
- BCD decrement with borrow:
  - sec_ones 0 -> 9 with borrow into sec_tens.
  - sec_tens 0 -> 5 with borrow into min_ones.
  - min_ones 0 -> 9 with borrow into min_tens.
  - Range is 00:00 to 99:59.
- If a decrement yields 00:00, the next state is DONE on the same edge, so done goes high with digits already 00:00.
- DONE lasts exactly one cycle, then IDLE.
- In RUN, stop or door_closed=0 goes to PAUSE. The prescaler and digits are held, with no decrement on that edge.
- start and stop in the same cycle: stop wins. From IDLE this is a no-op.
- start while already in RUN: no effect. stop in IDLE or PAUSE: no effect.
- Door opening during DONE: no effect (DONE still goes to IDLE).
- reset mid-RUN: returns to the reset state on the next edge and overrides all other inputs.

Test Plan:
- TICKS_PER_SEC=4. Reset, then load 00:03, then start with door_closed=1 → running=1 on the next edge. Digits show 00:02, 00:01, 00:00 at start+4, +8 and +12 cycles. done pulses for 1 cycle at +12, then running=0 and zero=1.
- Load 10:00 and start → after 1 second the digits read 09:59. Borrow chain check: load 01:00 → 00:59.
- Run from 00:05. After 6 cycles door_closed=0 → PAUSE: running=0, digits frozen at 00:04. Close the door and pulse start → next decrement after the remaining 2 cycles (prescaler retained).
- start and stop pulsed together in RUN → PAUSE. clear during RUN at 00:07 → digits 00:00, IDLE, no done pulse.
- Load ld digits 12 (min_tens), 7, 8, 12 (sec_ones) → stored as 97:59. start with value 00:00 → stays IDLE, running=0.
- Load pulsed during RUN → ignored, countdown continues. reset asserted mid-RUN → all outputs 0 on the next edge.
